// File: rtl/l1_mmu_pkg.sv
// Shared encodings for the L1-to-MMU port arbiter: grant owners, FSM states,
// request types and the cache-line width.
package l1_mmu_pkg;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IC   = 2'b01,
        GNT_DC   = 2'b10
    } gnt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;

endpackage

// File: rtl/l1_mmu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 of the request/grant vectors is the
// icache, bit 1 the dcache; the last-winner memory only moves on a strobed tie.
module rr_arb2
    import l1_mmu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic r_last_dc;

    // Grant selection: a lone requester wins, a tie goes to whoever did not win the last tie
    always_comb begin
        o_gnt = GNT_NONE;
        case (i_req)
            2'b01:   o_gnt = GNT_IC;
            2'b10:   o_gnt = GNT_DC;
            2'b11:   o_gnt = r_last_dc ? GNT_IC : GNT_DC;
            default: o_gnt = GNT_NONE;
        endcase
    end

    // Last-winner memory, reset to IC so the first tie goes to DC
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_dc <= 1'b0;
        end else if (i_update) begin
            r_last_dc <= (o_gnt == GNT_DC);
        end else begin
            r_last_dc <= r_last_dc;
        end
    end

endmodule

// File: rtl/l1_mmu_arbiter.sv
// Shares the single L1-to-MMU line port between the icache and dcache: latches
// the winning request, routes the completion back and watches MMU latency.
module l1_mmu_arbiter
    import l1_mmu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
)(
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              ic_req_read,
    input  logic [31:0]       ic_req_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_req_read,
    input  logic              dc_req_write,
    input  logic [31:0]       dc_req_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_read_data,
    output logic              mmu_req_read,
    output logic              mmu_req_write,
    output logic [31:0]       mmu_req_addr,
    output logic [LINE_W-1:0] mmu_write_data,
    input  logic              mmu_done,
    input  logic [LINE_W-1:0] mmu_read_data,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] WD_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_e          r_state;
    req_type_e       r_typ;
    logic            r_orphan;
    logic [TO_W-1:0] r_wd;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_tie;
    logic       w_owner_hold;
    logic       w_fwd;

    assign w_req = {dc_req_read | dc_req_write, ic_req_read};
    assign w_tie = (r_state == ST_IDLE) && (w_req == 2'b11);

    rr_arb2 u_rr_arb2 (
        .i_clk    (sys_clk),
        .i_rst    (rst),
        .i_req    (w_req),
        .i_update (w_tie),
        .o_gnt    (w_gnt)
    );

    // Is the owner still asserting the request type that was latched?
    always_comb begin
        w_owner_hold = 1'b0;
        case (grant)
            GNT_IC:  w_owner_hold = ic_req_read;
            GNT_DC:  w_owner_hold = (r_typ == REQ_WR) ? dc_req_write : dc_req_read;
            default: w_owner_hold = 1'b0;
        endcase
    end

    // Completion is forwarded in the same cycle as mmu_done, and only to a live owner
    assign w_fwd        = (r_state == ST_BUSY) && mmu_done && !r_orphan;
    assign ic_done      = w_fwd && (grant == GNT_IC);
    assign dc_done      = w_fwd && (grant == GNT_DC);
    assign ic_read_data = ic_done ? mmu_read_data : {LINE_W{1'b0}};
    assign dc_read_data = dc_done ? mmu_read_data : {LINE_W{1'b0}};

    // Request latch, IDLE/BUSY sequencing, orphan tracking and watchdog
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_typ          <= REQ_RD;
            r_orphan       <= 1'b0;
            r_wd           <= {TO_W{1'b0}};
            grant          <= GNT_NONE;
            mmu_req_read   <= 1'b0;
            mmu_req_write  <= 1'b0;
            mmu_req_addr   <= 32'h0000_0000;
            mmu_write_data <= {LINE_W{1'b0}};
            timeout_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wd     <= {TO_W{1'b0}};
                    r_orphan <= 1'b0;
                    if (w_gnt == GNT_DC) begin
                        r_state      <= ST_BUSY;
                        grant        <= GNT_DC;
                        mmu_req_addr <= dc_req_addr;
                        // A simultaneous read+write is illegal; the write takes it
                        if (dc_req_write) begin
                            r_typ          <= REQ_WR;
                            mmu_req_write  <= 1'b1;
                            mmu_req_read   <= 1'b0;
                            mmu_write_data <= dc_write_data;
                        end else begin
                            r_typ          <= REQ_RD;
                            mmu_req_write  <= 1'b0;
                            mmu_req_read   <= 1'b1;
                            mmu_write_data <= {LINE_W{1'b0}};
                        end
                    end else if (w_gnt == GNT_IC) begin
                        r_state        <= ST_BUSY;
                        grant          <= GNT_IC;
                        r_typ          <= REQ_RD;
                        mmu_req_addr   <= ic_req_addr;
                        mmu_req_read   <= 1'b1;
                        mmu_req_write  <= 1'b0;
                        mmu_write_data <= {LINE_W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                    end else begin
                        timeout_err <= timeout_err;
                    end
                    if (mmu_done) begin
                        r_state       <= ST_IDLE;
                        grant         <= GNT_NONE;
                        mmu_req_read  <= 1'b0;
                        mmu_req_write <= 1'b0;
                        r_orphan      <= 1'b0;
                        r_wd          <= {TO_W{1'b0}};
                    end else begin
                        if (r_wd != WD_MAX) begin
                            r_wd <= r_wd + WD_ONE;
                        end else begin
                            r_wd <= r_wd;
                        end
                        // An abandoned transaction still runs to completion, silently
                        if (!w_owner_hold) begin
                            r_orphan <= 1'b1;
                        end else begin
                            r_orphan <= r_orphan;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    grant   <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Randomized scoreboard bench for l1_mmu_arbiter: a transaction-level model
// predicts MMU request order and completions; a monitor compares them.
module tb_l1_mmu_arbiter;
    import l1_mmu_pkg::*;

    typedef struct {
        logic [1:0]   who;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           lat;
    } txn_t;

    logic         sys_clk;
    logic         rst;
    logic         ic_req_read;
    logic [31:0]  ic_req_addr;
    logic         ic_done;
    logic [255:0] ic_read_data;
    logic         dc_req_read;
    logic         dc_req_write;
    logic [31:0]  dc_req_addr;
    logic [255:0] dc_write_data;
    logic         dc_done;
    logic [255:0] dc_read_data;
    logic         mmu_req_read;
    logic         mmu_req_write;
    logic [31:0]  mmu_req_addr;
    logic [255:0] mmu_write_data;
    logic         mmu_done;
    logic [255:0] mmu_read_data;
    logic [1:0]   grant;
    logic         timeout_err;

    l1_mmu_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr),
        .ic_done(ic_done), .ic_read_data(ic_read_data),
        .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_write_data(dc_write_data),
        .dc_done(dc_done), .dc_read_data(dc_read_data),
        .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write),
        .mmu_req_addr(mmu_req_addr), .mmu_write_data(mmu_write_data),
        .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
        .grant(grant), .timeout_err(timeout_err)
    );

    int   checks = 0;
    int   errors = 0;
    txn_t ic_list[$];
    txn_t dc_list[$];
    txn_t plan[$];
    txn_t exp_mmu[$];
    txn_t exp_done[$];
    txn_t ic_q[$];
    txn_t dc_q[$];
    txn_t cur_plan;
    txn_t cur_exp;
    txn_t t;
    bit   model_last_dc = 1'b0;
    int   mmu_cnt = 0;
    bit   stray = 1'b0;
    bit   saw_ic;
    bit   saw_dc;
    logic [1:0] prev_grant;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [255:0] wdata, input int lat);
        txn_t x;
        x.who   = 2'b00;
        x.wr    = wr;
        x.addr  = addr;
        x.wdata = wr ? wdata : 256'd0;
        x.rdata = rand256();
        x.lat   = lat;
        return x;
    endfunction

    // Requesters present their head request; address/data are scrambled while the port is busy
    task automatic drive_inputs();
        bit busy;
        busy = mmu_req_read || mmu_req_write;
        ic_req_read = (ic_list.size() != 0);
        if (dc_list.size() != 0) begin
            dc_req_write = dc_list[0].wr;
            dc_req_read  = !dc_list[0].wr;
        end else begin
            dc_req_write = 1'b0;
            dc_req_read  = 1'b0;
        end
        if (busy || ic_list.size() == 0) ic_req_addr = $urandom;
        else ic_req_addr = ic_list[0].addr;
        if (busy || dc_list.size() == 0) begin
            dc_req_addr   = $urandom;
            dc_write_data = rand256();
        end else begin
            dc_req_addr   = dc_list[0].addr;
            dc_write_data = dc_list[0].wdata;
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        saw_ic = ic_done;
        saw_dc = dc_done;
        @(posedge sys_clk);
        #1;
        if (saw_ic && ic_list.size() != 0) ic_list.delete(0);
        if (saw_dc && dc_list.size() != 0) dc_list.delete(0);
        drive_inputs();
        mmu_done      = 1'b0;
        mmu_read_data = rand256();
        if (mmu_req_read || mmu_req_write) begin
            mmu_cnt++;
            if (mmu_cnt == 1) begin
                if (plan.size() != 0) cur_plan = plan.pop_front();
                else cur_plan.lat = 100000;
            end
            if (mmu_cnt == cur_plan.lat) begin
                mmu_done      = 1'b1;
                mmu_read_data = cur_plan.rdata;
            end
        end else begin
            mmu_cnt = 0;
        end
        if (stray) mmu_done = 1'b1;
    endtask

    // Reference model: requests all raised together, served one at a time,
    // ties go to the side that did not win the previous tie
    task automatic issue_round();
        txn_t a[$];
        txn_t b[$];
        txn_t x;
        bit   pick_dc;
        a = ic_q;
        b = dc_q;
        foreach (ic_q[i]) ic_list.push_back(ic_q[i]);
        foreach (dc_q[i]) dc_list.push_back(dc_q[i]);
        while (a.size() != 0 || b.size() != 0) begin
            if (a.size() != 0 && b.size() != 0) begin
                pick_dc = !model_last_dc;
                model_last_dc = pick_dc;
            end else begin
                pick_dc = (b.size() != 0);
            end
            if (pick_dc) begin
                x = b.pop_front();
                x.who = GNT_DC;
            end else begin
                x = a.pop_front();
                x.who = GNT_IC;
            end
            exp_mmu.push_back(x);
            plan.push_back(x);
            exp_done.push_back(x);
        end
        drive_inputs();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_done.size() != 0 || grant != 2'b00 || ic_list.size() != 0 || dc_list.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    // Monitor: new grants and every completion are checked against the model queues
    initial begin
        prev_grant = 2'b00;
        forever begin
            @(negedge sys_clk);
            if (rst === 1'b0) begin
                if (grant != 2'b00 && prev_grant == 2'b00) begin
                    if (exp_mmu.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got %0h expected none", grant);
                    end else begin
                        cur_exp = exp_mmu.pop_front();
                        chk("grant_owner", grant, cur_exp.who);
                        chk("mmu_req_write", mmu_req_write, cur_exp.wr);
                        chk("mmu_req_read", mmu_req_read, !cur_exp.wr);
                    end
                end
                if (grant != 2'b00) begin
                    chk("mmu_addr_hold", mmu_req_addr, cur_exp.addr);
                    chk("mmu_wdata_hold", mmu_write_data, cur_exp.wdata);
                end
                if (ic_done || dc_done) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got ic=%0b dc=%0b expected none", ic_done, dc_done);
                    end else begin
                        t = exp_done.pop_front();
                        chk("done_owner", {dc_done, ic_done}, t.who);
                        chk("done_data", ic_done ? ic_read_data : dc_read_data, t.rdata);
                    end
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        rst = 1'b1;
        ic_req_read = 1'b0; ic_req_addr = 32'h0; dc_req_read = 1'b0; dc_req_write = 1'b0;
        dc_req_addr = 32'h0; dc_write_data = 256'd0; mmu_done = 1'b0; mmu_read_data = 256'd0;
        repeat (3) tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_req_read", mmu_req_read, 1'b0);
        chk("rst_req_write", mmu_req_write, 1'b0);
        chk("rst_addr", mmu_req_addr, 32'h0);
        chk("rst_dones", {dc_done, ic_done}, 2'b00);
        chk("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;
        tick();

        // Single IC fill of 0x1000, done after 5 cycles with 0xA5 pattern
        ic_q.delete(); dc_q.delete();
        t = mk(1'b0, 32'h0000_1000, 256'd0, 5);
        t.rdata = {32{8'hA5}};
        ic_q.push_back(t);
        issue_round();
        chk("req_not_cycle0", mmu_req_read, 1'b0);
        tick();
        chk("req_cycle1", mmu_req_read, 1'b1);
        chk("addr_cycle1", mmu_req_addr, 32'h0000_1000);
        wait_idle("ic_single", 50);

        // Two ties in a row: DC then IC wins
        repeat (2) begin
            ic_q.delete(); dc_q.delete();
            ic_q.push_back(mk(1'b0, $urandom, 256'd0, $urandom_range(8, 1)));
            dc_q.push_back(mk(1'b0, $urandom, 256'd0, $urandom_range(8, 1)));
            issue_round();
            wait_idle("tie_round", 80);
        end

        // DC writeback then fill of the same line, IC pending
        ic_q.delete(); dc_q.delete();
        ic_q.push_back(mk(1'b0, $urandom, 256'd0, 3));
        dc_q.push_back(mk(1'b1, 32'h8000_0020, {8{32'h1234_5678}}, 6));
        dc_q.push_back(mk(1'b0, 32'h8000_0020, 256'd0, 4));
        issue_round();
        wait_idle("flush_round", 100);

        for (int r = 0; r < 25; r++) begin
            ic_q.delete(); dc_q.delete();
            if ($urandom_range(1, 0) == 1) ic_q.push_back(mk(1'b0, $urandom, 256'd0, $urandom_range(8, 1)));
            for (int k = 0; k < $urandom_range(2, 0); k++)
                dc_q.push_back(mk($urandom_range(1, 0) == 1, $urandom, rand256(), $urandom_range(8, 1)));
            issue_round();
            wait_idle("rand_round", 150);
            if ($urandom_range(3, 0) == 0) tick();
        end
        chk("no_timeout_short", timeout_err, 1'b0);

        // Orphan: DC read dropped in BUSY cycle 2, MMU done in cycle 6
        t = mk(1'b0, $urandom, 256'd0, 6);
        t.who = GNT_DC;
        exp_mmu.push_back(t);
        plan.push_back(t);
        dc_list.push_back(t);
        drive_inputs();
        tick();
        chk("orphan_granted", grant, GNT_DC);
        tick();
        dc_list.delete();
        drive_inputs();
        repeat (4) tick();
        chk("orphan_swallowed", {dc_done, ic_done}, 2'b00);
        tick();
        chk("orphan_idle_c7", grant, 2'b00);
        ic_q.delete(); dc_q.delete();
        dc_q.push_back(mk(1'b0, $urandom, 256'd0, 2));
        issue_round();
        wait_idle("orphan_rereq", 50);

        // Watchdog with done withheld for 20 BUSY cycles
        ic_q.delete(); dc_q.delete();
        ic_q.push_back(mk(1'b0, $urandom, 256'd0, 20));
        issue_round();
        for (int n = 0; n < 40 && mmu_cnt < 16; n++) tick();
        chk("wd_after15", timeout_err, 1'b0);
        tick();
        chk("wd_after16", timeout_err, 1'b1);
        wait_idle("wd_txn", 50);
        repeat (3) tick();
        chk("wd_sticky", timeout_err, 1'b1);
        rst = 1'b1;
        model_last_dc = 1'b0;
        tick();
        rst = 1'b0;
        chk("wd_cleared", timeout_err, 1'b0);

        // Reset mid-BUSY, then a stray MMU done
        t = mk(1'b1, $urandom, rand256(), 100000);
        t.who = GNT_DC;
        exp_mmu.push_back(t);
        plan.push_back(t);
        dc_list.push_back(t);
        drive_inputs();
        repeat (3) tick();
        chk("busy_before_rst", grant, GNT_DC);
        rst = 1'b1;
        model_last_dc = 1'b0;
        dc_list.delete();
        drive_inputs();
        tick();
        rst = 1'b0;
        chk("rst_busy_grant", grant, 2'b00);
        chk("rst_busy_reqs", {mmu_req_write, mmu_req_read}, 2'b00);
        stray = 1'b1;
        tick();
        chk("stray_done", {dc_done, ic_done}, 2'b00);
        chk("stray_grant", grant, 2'b00);
        stray = 1'b0;
        tick();

        chk("exp_mmu_drained", exp_mmu.size(), 0);
        chk("exp_done_drained", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
